ram_param_sc: RTL and testbench
===============================

Name: ram_param_sc

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 512x16 RAM.
- Generalised in data width and depth.
- Adds an accept/valid handshake, a selectable read-during-write mode and an optional output pipeline register.
- Adds a hardware clear engine that zero-fills every word after reset or on request.
- Serves as the general memory primitive for the register-file and memory-unit builds.

Parameters:
WIDTH, 16, data word width in bits (>=1)
ADDR_BITS, 9, address width; depth = 2**ADDR_BITS words
RDW_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high; starts a clear sweep
req  input  1  access request, accepted only when ready=1
load  input  1  with an accepted req: 1 = write, 0 = read
address  input  ADDR_BITS  word address
value  input  WIDTH  write data
clear  input  1  pulse in IDLE starts a zero-fill sweep
ready  output  1  1 = IDLE, accepting requests
out  output  WIDTH  read data
out_valid  output  1  one-cycle strobe, out holds data for an accepted access
clear_done  output  1  one-cycle pulse on the final sweep write

Behaviour:
- Reset, clk edge with reset=1:
  - state<=CLEAR, sweep counter<=0.
  - ready, out_valid and clear_done all 0.
  - out<=0; pipeline valid bits cleared.
  - Reset overrides everything, including a sweep in progress (the sweep restarts from address 0).
- FSM states CLEAR and IDLE:
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++. When cnt == 2**ADDR_BITS-1, write it, pulse clear_done=1 the same cycle, go to IDLE.
  - A sweep takes exactly 2**ADDR_BITS cycles. ready=0 throughout.
  - IDLE: ready=1. clear=1 -> CLEAR with cnt<=0 and ready dropping next cycle. clear has priority: a req in the same cycle is dropped (no write, no valid).
- Accepted access = req & ready & !clear at a posedge.
  - A write stores value to mem[address].
  - Every accepted access, read or write, also reads mem[address] and returns it with out_valid.
- Requests seen while ready=0 are ignored entirely; there is no queueing and no error flag.
- Read-during-write on an accepted write returns the old word if RDW_MODE=0, and value if RDW_MODE=1.
- Latency:
  - OUT_REG=0: out and out_valid update on the edge following acceptance (latency 1).
  - OUT_REG=1: one further register stage (latency 2).
  - out holds its last value when out_valid=0.
- Back-to-back accepted accesses sustain 1 per cycle; out_valid is asserted on consecutive cycles.
- Reads already in flight when clear is accepted still complete with pre-clear data. Reset cancels them.
- The memory array is not reset by reset itself; the sweep is the only initialisation. Reads before the first clear_done are impossible because ready=0.
- Address is always in range (full 2**ADDR_BITS decode); no wrap logic beyond the sweep counter width.

Test Plan:
1. Default params; reset 1 cycle -> ready=0 for 512 cycles, clear_done pulses on cycle 512, ready=1 next; reads at addresses 0, 255 and 511 return 0 with out_valid one cycle after req.
2. Write 16'hBEEF to address 9'h1A3, then read 9'h1A3 -> out=16'hBEEF, out_valid one cycle after the read req; read 9'h1A2 -> 0.
3. RDW_MODE=0, mem[5]=16'h1111; write 16'h2222 to 5 -> out=16'h1111. Repeat with RDW_MODE=1 -> out=16'h2222. A later read of 5 returns 16'h2222 in both cases.
4. OUT_REG=1, WIDTH=8, ADDR_BITS=4; write 8'h00 to 8'h0F in addresses 0-15, then read 0-15 back-to-back -> out_valid high 16 consecutive cycles, each data word 2 cycles after its req, values 8'h00 to 8'h0F in order.
5. Read address 3 issued, then clear pulsed the next cycle:
   - The read still returns its data.
   - A req during the clear cycle yields no out_valid.
   - ready=0 for 2**ADDR_BITS cycles.
   - A read of 3 after clear_done returns 0.
6. reset asserted at sweep cycle 100 -> sweep restarts, clear_done arrives 512 cycles after reset deassertion; req with load=1 during the sweep leaves the memory unchanged (read-back 0).

Source files
------------

// File: rtl/ram_param_sc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_param_sc : parameterised single-port synchronous RAM with request
//                handshake, read-during-write select, optional output stage
//                and a zero-fill clear sweep.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module ram_param_sc #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 9,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_i,
  input  logic                 load_i,
  input  logic [ADDR_BITS-1:0] address_i,
  input  logic [WIDTH-1:0]     value_i,
  input  logic                 clear_i,
  output logic                 ready_o,
  output logic [WIDTH-1:0]     out_o,
  output logic                 out_valid_o,
  output logic                 clear_done_o
);

  localparam int                   C_DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] C_LAST_ADDR = '1;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     mem_q [C_DEPTH];
  logic [WIDTH-1:0]     rd_data_q;
  logic                 rd_valid_q;
  logic                 w_accept;
  logic                 w_sweep_last;
  logic [WIDTH-1:0]     w_rd_word;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + ADDR_BITS'(1);
        if (w_sweep_last) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_o      = (state_q == S_IDLE);
  assign w_sweep_last = (state_q == S_CLEAR) && (cnt_q == C_LAST_ADDR);
  assign clear_done_o = w_sweep_last;
  // clear wins over a simultaneous request
  assign w_accept     = req_i && ready_o && !clear_i;

  // The array itself is never reset; the sweep is its only initialisation.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (w_accept && load_i) begin
        mem_q[address_i] <= value_i;
      end
    end
  end

  generate
    if (RDW_MODE != 0) begin : g_write_first
      assign w_rd_word = load_i ? value_i : mem_q[address_i];
    end else begin : g_read_first
      assign w_rd_word = mem_q[address_i];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= w_accept;
      if (w_accept) rd_data_q <= w_rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      logic             out_valid_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) out_q <= rd_data_q;
        end
      end

      assign out_o       = out_q;
      assign out_valid_o = out_valid_q;
    end else begin : g_no_out_reg
      assign out_o       = rd_data_q;
      assign out_valid_o = rd_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_param_sc.sv
`default_nettype none
// tb_ram_param_sc : randomised bench comparing three ram_param_sc builds
// (read-first, write-first, pipelined 8-bit x 16) against a behavioural model.
module tb_ram_param_sc;

  typedef struct {
    bit          rst;
    bit          req;
    bit          load;
    bit          clr;
    logic [8:0]  addr;
    logic [15:0] val;
    bit          chk;
    logic [15:0] e0;
    logic [15:0] e1;
  } op_a_t;

  typedef struct {
    bit         rst;
    bit         req;
    bit         load;
    bit         clr;
    logic [3:0] addr;
    logic [7:0] val;
  } op_b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // group A: two default-size instances sharing stimulus
  logic        a_rst, a_req, a_load, a_clr;
  logic [8:0]  a_addr;
  logic [15:0] a_val;
  logic        a0_ready, a0_done, a0_valid, a1_ready, a1_done, a1_valid;
  logic [15:0] a0_out, a1_out;

  // group B: pipelined small instance
  logic        b_rst, b_req, b_load, b_clr;
  logic [3:0]  b_addr;
  logic [7:0]  b_val;
  logic        b_ready, b_done, b_valid;
  logic [7:0]  b_out;

  ram_param_sc #(.WIDTH(16), .ADDR_BITS(9), .RDW_MODE(0), .OUT_REG(0)) u_rf (
    .clk_i(clk), .reset_i(a_rst), .req_i(a_req), .load_i(a_load), .address_i(a_addr),
    .value_i(a_val), .clear_i(a_clr), .ready_o(a0_ready), .out_o(a0_out),
    .out_valid_o(a0_valid), .clear_done_o(a0_done));

  ram_param_sc #(.WIDTH(16), .ADDR_BITS(9), .RDW_MODE(1), .OUT_REG(0)) u_wf (
    .clk_i(clk), .reset_i(a_rst), .req_i(a_req), .load_i(a_load), .address_i(a_addr),
    .value_i(a_val), .clear_i(a_clr), .ready_o(a1_ready), .out_o(a1_out),
    .out_valid_o(a1_valid), .clear_done_o(a1_done));

  ram_param_sc #(.WIDTH(8), .ADDR_BITS(4), .RDW_MODE(0), .OUT_REG(1)) u_pipe (
    .clk_i(clk), .reset_i(b_rst), .req_i(b_req), .load_i(b_load), .address_i(b_addr),
    .value_i(b_val), .clear_i(b_clr), .ready_o(b_ready), .out_o(b_out),
    .out_valid_o(b_valid), .clear_done_o(b_done));

  // reference model state
  logic [15:0] ma_mem [512];
  bit          ma_ready;
  int          ma_left;
  bit          ea_valid;
  logic [15:0] ea_out0, ea_out1;

  logic [7:0]  mb_mem [16];
  bit          mb_ready;
  int          mb_left;
  bit          eb_valid;
  logic [7:0]  eb_out;
  bit          sb_v;
  logic [7:0]  sb_d;

  int checks = 0;
  int errors = 0;

  function automatic op_a_t mk_a(bit req, bit load, logic [8:0] addr, logic [15:0] val,
                                 bit clr, bit rst, bit chk, logic [15:0] e0, logic [15:0] e1);
    op_a_t o;
    o.req = req; o.load = load; o.addr = addr; o.val = val; o.clr = clr; o.rst = rst;
    o.chk = chk; o.e0 = e0; o.e1 = e1;
    return o;
  endfunction

  task automatic drive_a(input op_a_t o);
    a_rst = o.rst; a_req = o.req; a_load = o.load; a_addr = o.addr; a_val = o.val; a_clr = o.clr;
  endtask

  task automatic drive_b(input op_b_t o);
    b_rst = o.rst; b_req = o.req; b_load = o.load; b_addr = o.addr; b_val = o.val; b_clr = o.clr;
  endtask

  // One clock edge, then advance the model with the inputs that edge saw.
  task automatic cyc();
    logic [15:0] old_a;
    logic [7:0]  nd;
    bit          nv;
    @(posedge clk);
    #1;
    if (a_rst) begin
      ma_ready = 0; ma_left = 512; ea_valid = 0; ea_out0 = '0; ea_out1 = '0;
    end else if (!ma_ready) begin
      ma_left--; ea_valid = 0;
      if (ma_left == 0) begin
        ma_ready = 1;
        foreach (ma_mem[i]) ma_mem[i] = '0;
      end
    end else if (a_clr) begin
      ma_ready = 0; ma_left = 512; ea_valid = 0;
    end else if (a_req) begin
      old_a   = ma_mem[a_addr];
      ea_out0 = old_a;
      ea_out1 = a_load ? a_val : old_a;
      if (a_load) ma_mem[a_addr] = a_val;
      ea_valid = 1;
    end else begin
      ea_valid = 0;
    end

    nv = 0; nd = '0;
    if (b_rst) begin
      mb_ready = 0; mb_left = 16; sb_v = 0; eb_valid = 0; eb_out = '0;
    end else begin
      if (!mb_ready) begin
        mb_left--;
        if (mb_left == 0) begin
          mb_ready = 1;
          foreach (mb_mem[i]) mb_mem[i] = '0;
        end
      end else if (b_clr) begin
        mb_ready = 0; mb_left = 16;
      end else if (b_req) begin
        nd = mb_mem[b_addr];
        if (b_load) mb_mem[b_addr] = b_val;
        nv = 1;
      end
      eb_valid = sb_v;
      if (sb_v) eb_out = sb_d;
      sb_v = nv; sb_d = nd;
    end
    a_rst = 0; a_req = 0; a_clr = 0; b_rst = 0; b_req = 0; b_clr = 0;
  endtask

  task automatic test_reset();
    int  first_a = -1;
    int  first_b = -1;
    bit  xd;
    for (int k = 0; k < 520; k++) begin
      if (k == 0) begin a_rst = 1; b_rst = 1; end
      cyc();
      if (first_a < 0 && a0_ready === 1'b1) first_a = k;
      if (first_b < 0 && b_ready === 1'b1) first_b = k;
      xd = !ma_ready && ma_left == 1;
      checks += 8;
      if (a0_ready !== ma_ready) begin errors++; $display("FAIL reset a0_ready: got %b want %b", a0_ready, ma_ready); end
      if (a1_ready !== ma_ready) begin errors++; $display("FAIL reset a1_ready: got %b want %b", a1_ready, ma_ready); end
      if (a0_done !== xd) begin errors++; $display("FAIL reset a0_done k=%0d: got %b want %b", k, a0_done, xd); end
      if (a1_done !== xd) begin errors++; $display("FAIL reset a1_done k=%0d: got %b want %b", k, a1_done, xd); end
      if (a0_valid !== ea_valid) begin errors++; $display("FAIL reset a0_valid: got %b want %b", a0_valid, ea_valid); end
      if (a1_valid !== ea_valid) begin errors++; $display("FAIL reset a1_valid: got %b want %b", a1_valid, ea_valid); end
      if (a0_out !== ea_out0) begin errors++; $display("FAIL reset a0_out: got %h want %h", a0_out, ea_out0); end
      if (a1_out !== ea_out1) begin errors++; $display("FAIL reset a1_out: got %h want %h", a1_out, ea_out1); end
      xd = !mb_ready && mb_left == 1;
      checks += 4;
      if (b_ready !== mb_ready) begin errors++; $display("FAIL reset b_ready: got %b want %b", b_ready, mb_ready); end
      if (b_done !== xd) begin errors++; $display("FAIL reset b_done k=%0d: got %b want %b", k, b_done, xd); end
      if (b_valid !== eb_valid) begin errors++; $display("FAIL reset b_valid: got %b want %b", b_valid, eb_valid); end
      if (b_out !== eb_out) begin errors++; $display("FAIL reset b_out: got %h want %h", b_out, eb_out); end
    end
    checks += 2;
    if (first_a != 512) begin errors++; $display("FAIL reset a_sweep_len: got %0d want 512", first_a); end
    if (first_b != 16) begin errors++; $display("FAIL reset b_sweep_len: got %0d want 16", first_b); end
  endtask

  task automatic test_access();
    op_a_t q[$];
    bit    xd;
    q.push_back(mk_a(1, 0, 9'd0,   16'h0,    0, 0, 1, 16'h0,    16'h0));
    q.push_back(mk_a(1, 0, 9'd255, 16'h0,    0, 0, 1, 16'h0,    16'h0));
    q.push_back(mk_a(1, 0, 9'd511, 16'h0,    0, 0, 1, 16'h0,    16'h0));
    q.push_back(mk_a(1, 1, 9'h1A3, 16'hBEEF, 0, 0, 0, 16'h0,    16'h0));
    q.push_back(mk_a(1, 0, 9'h1A3, 16'h0,    0, 0, 1, 16'hBEEF, 16'hBEEF));
    q.push_back(mk_a(1, 0, 9'h1A2, 16'h0,    0, 0, 1, 16'h0,    16'h0));
    q.push_back(mk_a(1, 1, 9'd5,   16'h1111, 0, 0, 0, 16'h0,    16'h0));
    q.push_back(mk_a(1, 1, 9'd5,   16'h2222, 0, 0, 1, 16'h1111, 16'h2222));
    q.push_back(mk_a(1, 0, 9'd5,   16'h0,    0, 0, 1, 16'h2222, 16'h2222));
    for (int i = 0; i < 300; i++)
      q.push_back(mk_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                       ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 15)) : 9'($urandom),
                       16'($urandom), 0, 0, 0, 16'h0, 16'h0));
    foreach (q[i]) begin
      drive_a(q[i]);
      cyc();
      xd = !ma_ready && ma_left == 1;
      checks += 6;
      if (a0_ready !== ma_ready) begin errors++; $display("FAIL access a0_ready: got %b want %b", a0_ready, ma_ready); end
      if (a0_done !== xd) begin errors++; $display("FAIL access a0_done: got %b want %b", a0_done, xd); end
      if (a0_valid !== ea_valid) begin errors++; $display("FAIL access a0_valid op %0d: got %b want %b", i, a0_valid, ea_valid); end
      if (a1_valid !== ea_valid) begin errors++; $display("FAIL access a1_valid op %0d: got %b want %b", i, a1_valid, ea_valid); end
      if (a0_out !== ea_out0) begin errors++; $display("FAIL access a0_out op %0d: got %h want %h", i, a0_out, ea_out0); end
      if (a1_out !== ea_out1) begin errors++; $display("FAIL access a1_out op %0d: got %h want %h", i, a1_out, ea_out1); end
      if (q[i].chk) begin
        checks += 3;
        if (a0_valid !== 1'b1) begin errors++; $display("FAIL access directed valid op %0d: got %b want 1", i, a0_valid); end
        if (a0_out !== q[i].e0) begin errors++; $display("FAIL access directed rf op %0d: got %h want %h", i, a0_out, q[i].e0); end
        if (a1_out !== q[i].e1) begin errors++; $display("FAIL access directed wf op %0d: got %h want %h", i, a1_out, q[i].e1); end
      end
    end
  endtask

  task automatic test_clear_inflight();
    op_a_t q[$];
    bit    xd;
    q.push_back(mk_a(1, 1, 9'd3, 16'hABCD, 0, 0, 0, 16'h0, 16'h0));
    q.push_back(mk_a(1, 0, 9'd3, 16'h0,    0, 0, 1, 16'hABCD, 16'hABCD));
    q.push_back(mk_a(1, 1, 9'd3, 16'h5555, 1, 0, 0, 16'h0, 16'h0));
    for (int i = 0; i < 512; i++)
      q.push_back(mk_a($urandom_range(0, 1) != 0, 1, 9'($urandom), 16'($urandom | 1), 0, 0, 0, 16'h0, 16'h0));
    q.push_back(mk_a(1, 0, 9'd3, 16'h0, 0, 0, 1, 16'h0, 16'h0));
    q.push_back(mk_a(0, 0, 9'd0, 16'h0, 0, 0, 0, 16'h0, 16'h0));
    foreach (q[i]) begin
      drive_a(q[i]);
      cyc();
      xd = !ma_ready && ma_left == 1;
      checks += 6;
      if (a0_ready !== ma_ready) begin errors++; $display("FAIL clear a0_ready op %0d: got %b want %b", i, a0_ready, ma_ready); end
      if (a0_done !== xd) begin errors++; $display("FAIL clear a0_done op %0d: got %b want %b", i, a0_done, xd); end
      if (a0_valid !== ea_valid) begin errors++; $display("FAIL clear a0_valid op %0d: got %b want %b", i, a0_valid, ea_valid); end
      if (a1_valid !== ea_valid) begin errors++; $display("FAIL clear a1_valid op %0d: got %b want %b", i, a1_valid, ea_valid); end
      if (a0_out !== ea_out0) begin errors++; $display("FAIL clear a0_out op %0d: got %h want %h", i, a0_out, ea_out0); end
      if (a1_out !== ea_out1) begin errors++; $display("FAIL clear a1_out op %0d: got %h want %h", i, a1_out, ea_out1); end
      if (q[i].chk) begin
        checks += 2;
        if (a0_valid !== 1'b1) begin errors++; $display("FAIL clear directed valid op %0d: got %b want 1", i, a0_valid); end
        if (a0_out !== q[i].e0) begin errors++; $display("FAIL clear directed out op %0d: got %h want %h", i, a0_out, q[i].e0); end
      end
    end
  endtask

  task automatic test_reset_midsweep();
    op_a_t      q[$];
    logic [8:0] hit[$];
    logic [8:0] ad;
    bit         xd;
    q.push_back(mk_a(0, 0, 9'd0, 16'h0, 0, 1, 0, 16'h0, 16'h0));
    for (int i = 0; i < 99; i++)
      q.push_back(mk_a(1, 1, 9'($urandom), 16'($urandom | 1), 0, 0, 0, 16'h0, 16'h0));
    q.push_back(mk_a(1, 1, 9'd7, 16'h7777, 0, 1, 0, 16'h0, 16'h0));
    for (int i = 0; i < 512; i++) begin
      ad = 9'($urandom);
      if (hit.size() < 16) hit.push_back(ad);
      q.push_back(mk_a(1, 1, ad, 16'($urandom | 1), 0, 0, 0, 16'h0, 16'h0));
    end
    foreach (hit[i]) q.push_back(mk_a(1, 0, hit[i], 16'h0, 0, 0, 1, 16'h0, 16'h0));
    foreach (q[i]) begin
      drive_a(q[i]);
      cyc();
      xd = !ma_ready && ma_left == 1;
      checks += 6;
      if (a0_ready !== ma_ready) begin errors++; $display("FAIL midsweep a0_ready op %0d: got %b want %b", i, a0_ready, ma_ready); end
      if (a0_done !== xd) begin errors++; $display("FAIL midsweep a0_done op %0d: got %b want %b", i, a0_done, xd); end
      if (a0_valid !== ea_valid) begin errors++; $display("FAIL midsweep a0_valid op %0d: got %b want %b", i, a0_valid, ea_valid); end
      if (a1_valid !== ea_valid) begin errors++; $display("FAIL midsweep a1_valid op %0d: got %b want %b", i, a1_valid, ea_valid); end
      if (a0_out !== ea_out0) begin errors++; $display("FAIL midsweep a0_out op %0d: got %h want %h", i, a0_out, ea_out0); end
      if (a1_out !== ea_out1) begin errors++; $display("FAIL midsweep a1_out op %0d: got %h want %h", i, a1_out, ea_out1); end
      if (q[i].chk) begin
        checks += 2;
        if (a0_valid !== 1'b1) begin errors++; $display("FAIL midsweep directed valid op %0d: got %b want 1", i, a0_valid); end
        if (a0_out !== q[i].e0) begin errors++; $display("FAIL midsweep directed out op %0d: got %h want %h", i, a0_out, q[i].e0); end
      end
    end
  endtask

  task automatic test_pipeline();
    op_b_t      q[$];
    op_b_t      o;
    logic [7:0] seen[$];
    bit         xd;
    for (int k = 0; k < 16; k++) begin
      o.rst = 0; o.clr = 0; o.req = 1; o.load = 1; o.addr = 4'(k); o.val = 8'(k);
      q.push_back(o);
    end
    for (int k = 0; k < 16; k++) begin
      o.rst = 0; o.clr = 0; o.req = 1; o.load = 0; o.addr = 4'(k); o.val = 8'hFF;
      q.push_back(o);
    end
    for (int k = 0; k < 3; k++) begin
      o.rst = 0; o.clr = 0; o.req = 0; o.load = 0; o.addr = 4'd0; o.val = 8'h0;
      q.push_back(o);
    end
    for (int k = 0; k < 250; k++) begin
      o.rst  = $urandom_range(0, 99) == 0;
      o.clr  = $urandom_range(0, 39) == 0;
      o.req  = $urandom_range(0, 3) != 0;
      o.load = $urandom_range(0, 1) != 0;
      o.addr = 4'($urandom);
      o.val  = 8'($urandom);
      q.push_back(o);
    end
    foreach (q[i]) begin
      drive_b(q[i]);
      cyc();
      if (i >= 17 && i <= 32 && b_valid === 1'b1) seen.push_back(b_out);
      xd = !mb_ready && mb_left == 1;
      checks += 4;
      if (b_ready !== mb_ready) begin errors++; $display("FAIL pipe b_ready op %0d: got %b want %b", i, b_ready, mb_ready); end
      if (b_done !== xd) begin errors++; $display("FAIL pipe b_done op %0d: got %b want %b", i, b_done, xd); end
      if (b_valid !== eb_valid) begin errors++; $display("FAIL pipe b_valid op %0d: got %b want %b", i, b_valid, eb_valid); end
      if (b_out !== eb_out) begin errors++; $display("FAIL pipe b_out op %0d: got %h want %h", i, b_out, eb_out); end
    end
    checks++;
    if (seen.size() != 16) begin errors++; $display("FAIL pipe burst_len: got %0d want 16", seen.size()); end
    foreach (seen[k]) begin
      checks++;
      if (seen[k] !== 8'(k)) begin errors++; $display("FAIL pipe burst_word %0d: got %h want %h", k, seen[k], 8'(k)); end
    end
  endtask

  initial begin
    a_rst = 0; a_req = 0; a_load = 0; a_clr = 0; a_addr = '0; a_val = '0;
    b_rst = 0; b_req = 0; b_load = 0; b_clr = 0; b_addr = '0; b_val = '0;
    ma_ready = 0; ma_left = 512; ea_valid = 0; ea_out0 = '0; ea_out1 = '0;
    mb_ready = 0; mb_left = 16; eb_valid = 0; eb_out = '0; sb_v = 0; sb_d = '0;
    foreach (ma_mem[i]) ma_mem[i] = '0;
    foreach (mb_mem[i]) mb_mem[i] = '0;
    test_reset();
    test_access();
    test_clear_inflight();
    test_reset_midsweep();
    test_pipeline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
